// File: rtl/icache_pkg.sv
// Shared constants for the instruction-cache fill path: FSM state encoding
// and the default word/address widths used by the icache top level.
package icache_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_REQ   = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam int ICACHE_DATABITS    = 32;
  localparam int ICACHE_ADDRBITS    = 5;
  localparam int ICACHE_MEMADDRBITS = 30;

endpackage

// File: rtl/icache_fill_ctrl.sv
// Line-fill controller for the instruction cache. On a fill request it takes
// the memory block over through the flush_* ports, reads one whole line from
// main memory a word per handshake, writes each word, then validates the tag.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | no fill in progress; hit check live, waits for fill_req
// ST_REQ   | mem_rd held for word cnt until mem_valid
// ST_WRITE | one-cycle flush_we of the captured word, advance cnt
// ST_DONE  | fill_done pulse, tag_valid set unless invalidated
module icache_fill_ctrl
  import icache_pkg::*;
#(
  parameter int DATABITS    = ICACHE_DATABITS,
  parameter int ADDRBITS    = ICACHE_ADDRBITS,
  parameter int MEMADDRBITS = ICACHE_MEMADDRBITS,
  parameter int TAGBITS     = MEMADDRBITS - ADDRBITS
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   fill_req,
  input  logic [MEMADDRBITS-1:0] fill_base,
  input  logic                   inval,
  input  logic [TAGBITS-1:0]     cpu_tag,
  output logic                   hit,
  output logic [TAGBITS-1:0]     tag_out,
  output logic                   tag_valid,
  output logic                   fill_busy,
  output logic                   fill_done,
  output logic                   mem_rd,
  output logic [MEMADDRBITS-1:0] mem_addr,
  input  logic                   mem_valid,
  input  logic [DATABITS-1:0]    mem_data,
  output logic                   flush_mode,
  output logic [ADDRBITS-1:0]    flush_addr,
  output logic [DATABITS-1:0]    flush_in,
  output logic                   flush_we
);

  localparam logic [ADDRBITS-1:0] CNT_LAST = '1;

  logic [1:0]          state;
  logic [ADDRBITS-1:0] cnt;
  // An invalidate seen mid-fill must still veto the tag_valid set in DONE.
  logic                inval_seen;

  // Word offset inside the line is irrelevant: fills always start at word 0.
  logic unused_base_bits;
  assign unused_base_bits = ^fill_base[ADDRBITS-1:0];

  // FSM, word counter, tag register and captured write data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      inval_seen <= 1'b0;
      tag_out    <= '0;
      tag_valid  <= 1'b0;
      flush_addr <= '0;
      flush_in   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (inval) tag_valid <= 1'b0;
          if (fill_req) begin
            tag_out    <= fill_base[MEMADDRBITS-1:ADDRBITS];
            cnt        <= '0;
            tag_valid  <= 1'b0;
            inval_seen <= 1'b0;
            state      <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (inval) inval_seen <= 1'b1;
          if (mem_valid) begin
            flush_in   <= mem_data;
            flush_addr <= cnt;
            state      <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          if (inval) inval_seen <= 1'b1;
          if (cnt == CNT_LAST) begin
            state <= ST_DONE;
          end else begin
            cnt   <= cnt + 1'b1;
            state <= ST_REQ;
          end
        end
        default: begin
          tag_valid <= !(inval || inval_seen);
          state     <= ST_IDLE;
        end
      endcase
    end
  end

  // Outputs decoded straight from the state register, so they are glitch-free
  // and drop to 0 the moment reset is asserted.
  always_comb begin
    fill_busy  = (state != ST_IDLE);
    fill_done  = (state == ST_DONE);
    mem_rd     = (state == ST_REQ);
    flush_we   = (state == ST_WRITE);
    flush_mode = (state == ST_REQ) || (state == ST_WRITE);
    mem_addr   = {tag_out, cnt};
    hit        = tag_valid && !fill_busy && (cpu_tag == tag_out);
  end

endmodule

// File: tb/tb_icache_fill_ctrl.sv
// Bench for icache_fill_ctrl: directed fills from a vector table plus
// randomized fills, checked against a cycle-count and word-list model.
module tb_icache_fill_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        fill_req;
  logic [29:0] fill_base;
  logic        inval;
  logic [24:0] cpu_tag;
  logic        hit;
  logic [24:0] tag_out;
  logic        tag_valid;
  logic        fill_busy;
  logic        fill_done;
  logic        mem_rd;
  logic [29:0] mem_addr;
  logic        mem_valid;
  logic [31:0] mem_data;
  logic        flush_mode;
  logic [4:0]  flush_addr;
  logic [31:0] flush_in;
  logic        flush_we;

  int total  = 0;
  int passed = 0;

  icache_fill_ctrl dut (
    .clk(clk), .reset_n(reset_n), .fill_req(fill_req), .fill_base(fill_base),
    .inval(inval), .cpu_tag(cpu_tag), .hit(hit), .tag_out(tag_out),
    .tag_valid(tag_valid), .fill_busy(fill_busy), .fill_done(fill_done),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_valid(mem_valid),
    .mem_data(mem_data), .flush_mode(flush_mode), .flush_addr(flush_addr),
    .flush_in(flush_in), .flush_we(flush_we)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [29:0] base;
    int          wmode;       // fixed wait cycles per word, -1 = random 0..3
    int          inval_word;  // pulse inval when this many words written, -1 none
    bit          noise;       // spurious fill_req / mem_valid during the fill
    int          reset_word;  // pulse reset_n when this many words written, -1 none
    int          exp_done;    // expected fill_done cycle, 0 = use model
    bit          exp_tv;      // expected tag_valid after the fill
    logic [31:0] salt;        // memory data = word address ^ salt
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic int pick_wait(input int wmode);
    if (wmode >= 0) return wmode;
    return int'($urandom_range(0, 3));
  endfunction

  task automatic idle_inputs();
    fill_req  = 1'b0;
    inval     = 1'b0;
    mem_valid = 1'b0;
    mem_data  = '0;
  endtask

  task automatic run_fill(input vec_t v);
    logic [24:0] tag;
    logic [29:0] waddr;
    int cyc, writes, waited, wait_k, exp_cyc;
    bit inval_done, fin;
    tag        = v.base[29:5];
    cyc        = 0;
    writes     = 0;
    waited     = 0;
    exp_cyc    = 1;
    inval_done = 1'b0;
    fin        = 1'b0;
    wait_k     = pick_wait(v.wmode);
    @(negedge clk);
    idle_inputs();
    fill_req  = 1'b1;
    fill_base = v.base;
    while (!fin && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      fill_req  = v.noise ? 1'($urandom_range(0, 1)) : 1'b0;
      fill_base = $urandom;
      inval     = 1'b0;
      mem_valid = v.noise ? 1'($urandom_range(0, 1)) : 1'b0;
      mem_data  = $urandom;
      if (v.reset_word >= 0 && writes == v.reset_word) begin
        reset_n = 1'b0;
        #1;
        chk("async_reset_zero", 64'(|{tag_out, tag_valid, fill_busy, fill_done, mem_rd,
            mem_addr, flush_mode, flush_addr, flush_in, flush_we, hit}), 64'd0);
        idle_inputs();
        @(negedge clk);
        chk("held_reset_zero", 64'(|{fill_busy, flush_we, flush_mode, mem_rd}), 64'd0);
        reset_n = 1'b1;
        return;
      end
      chk("busy_during_fill", 64'(fill_busy), 64'd1);
      waddr = {tag, writes[4:0]};
      if (mem_rd) begin
        chk("mem_addr", 64'(mem_addr), 64'(waddr));
        chk("mode_in_req", 64'(flush_mode), 64'd1);
        if (waited == wait_k) begin
          mem_valid = 1'b1;
          mem_data  = {2'b00, waddr} ^ v.salt;
          exp_cyc  += wait_k + 2;
          waited    = 0;
          wait_k    = pick_wait(v.wmode);
        end else begin
          mem_valid = 1'b0;
          waited++;
        end
      end
      if (flush_we) begin
        chk("mode_with_we", 64'(flush_mode), 64'd1);
        chk("flush_addr", 64'(flush_addr), 64'(writes[4:0]));
        chk("flush_in", 64'(flush_in), 64'({2'b00, tag, writes[4:0]} ^ v.salt));
        writes++;
      end
      if (fill_done) begin
        chk("done_cycle", 64'(cyc), 64'(v.exp_done != 0 ? v.exp_done : exp_cyc));
        chk("mode_off_in_done", 64'(flush_mode), 64'd0);
        fill_req = 1'b0;
        fin      = 1'b1;
      end
      if (v.inval_word >= 0 && writes == v.inval_word && !inval_done) begin
        inval      = 1'b1;
        inval_done = 1'b1;
      end
    end
    chk("fill_finished", 64'(fin), 64'd1);
    chk("word_count", 64'(writes), 64'd32);
    @(negedge clk);
    idle_inputs();
    chk("tag_out", 64'(tag_out), 64'(tag));
    chk("tag_valid_after", 64'(tag_valid), 64'(v.exp_tv));
    chk("idle_after_done", 64'(|{fill_busy, fill_done, mem_rd, flush_we}), 64'd0);
    cpu_tag = tag;
    #1;
    chk("hit_match", 64'(hit), 64'(v.exp_tv));
    cpu_tag = tag + 25'd1;
    #1;
    chk("hit_other_tag", 64'(hit), 64'd0);
  endtask

  initial begin
    vec_t rv;
    vecs[0] = '{base: 30'h0000_0123, wmode: 0, inval_word: -1, noise: 1'b0, reset_word: -1,
                exp_done: 65, exp_tv: 1'b1, salt: 32'h0};
    vecs[1] = '{base: 30'h0000_0123, wmode: 3, inval_word: -1, noise: 1'b0, reset_word: -1,
                exp_done: 161, exp_tv: 1'b1, salt: 32'h0};
    vecs[2] = '{base: 30'h3ABC_DE40, wmode: 0, inval_word: 10, noise: 1'b1, reset_word: -1,
                exp_done: 65, exp_tv: 1'b0, salt: 32'h0};
    vecs[3] = '{base: 30'h2000_0011, wmode: 1, inval_word: -1, noise: 1'b0, reset_word: 17,
                exp_done: 0, exp_tv: 1'b0, salt: 32'h0};
    vecs[4] = '{base: 30'h0000_0555, wmode: 1, inval_word: -1, noise: 1'b0, reset_word: -1,
                exp_done: 97, exp_tv: 1'b1, salt: 32'h0};

    reset_n   = 1'b0;
    fill_base = '0;
    cpu_tag   = '0;
    idle_inputs();
    #1;
    chk("reset_outputs_zero", 64'(|{tag_out, tag_valid, fill_busy, fill_done, mem_rd,
        mem_addr, flush_mode, flush_addr, flush_in, flush_we}), 64'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      cpu_tag = $urandom;
      if (i == 0) cpu_tag = '0;
      #1;
      chk("idle_hit_zero", 64'(hit), 64'd0);
      chk("idle_busy_zero", 64'(fill_busy), 64'd0);
    end

    for (int i = 0; i < 5; i++) run_fill(vecs[i]);

    for (int i = 0; i < 8; i++) begin
      rv.base       = $urandom;
      rv.wmode      = -1;
      rv.inval_word = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 32)) : -1;
      rv.noise      = 1'b1;
      rv.reset_word = -1;
      rv.exp_done   = 0;
      rv.exp_tv     = (rv.inval_word < 0);
      rv.salt       = $urandom;
      run_fill(rv);
    end

    // Invalidate from IDLE clears a valid line.
    run_fill(vecs[0]);
    @(negedge clk);
    inval = 1'b1;
    @(negedge clk);
    inval = 1'b0;
    cpu_tag = 25'h9;
    #1;
    chk("idle_inval_clears", 64'(tag_valid), 64'd0);
    chk("idle_inval_no_hit", 64'(hit), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/icache_fill_ctrl.md
Name: icache_fill_ctrl

Overview:
- Flush/line-fill controller for the instruction cache; sits directly upstream of the icache memory block.
- On a miss request it owns the memory block via flush_mode and reads one full line (2**ADDRBITS words) from main memory, one word per handshake.
- It writes each returned word into the memory block and then marks the line's tag valid.
- It also provides the combinational hit check against the stored tag.

Parameters:
- DATABITS, 32, width of one instruction word.
- ADDRBITS, 5, memory block word-address width; line length MEMSIZE = 2**ADDRBITS words.
- MEMADDRBITS, 30, main-memory word-address width; tag width TAGBITS = MEMADDRBITS-ADDRBITS.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- reset_n  in  1  reset, asynchronous, active-low.
- fill_req  in  1  start a line fill; sampled only in IDLE.
- fill_base  in  MEMADDRBITS  word address inside the line to fill; the low ADDRBITS bits are ignored.
- inval  in  1  clear tag_valid.
- cpu_tag  in  TAGBITS  tag of the current fetch address.
- hit  out  1  tag_valid && (cpu_tag == tag_out); combinational.
- tag_out  out  TAGBITS  tag of the resident line.
- tag_valid  out  1  resident line is complete and valid.
- fill_busy  out  1  high from the cycle after fill_req is accepted until the return to IDLE.
- fill_done  out  1  one-cycle pulse when the fill completes.
- mem_rd  out  1  read request; held until mem_valid.
- mem_addr  out  MEMADDRBITS  {tag_out, cnt}.
- mem_valid  in  1  read data valid; completes the current request.
- mem_data  in  DATABITS  read data.
- flush_mode  out  1  memory block address/data taken from flush_* ports.
- flush_addr  out  ADDRBITS  word index inside the line.
- flush_in  out  DATABITS  registered copy of mem_data.
- flush_we  out  1  write strobe; only ever high while flush_mode is high.

Behaviour:
- Reset (async, reset_n=0): state=IDLE, cnt=0. All outputs 0: tag_out, tag_valid, fill_busy, fill_done, mem_rd, mem_addr, flush_mode, flush_addr, flush_in, flush_we.
- Reset mid-fill aborts immediately; tag_valid stays 0 and no further writes occur.

State machine, registered outputs:
- IDLE:
  - fill_req=1 -> tag_out<=fill_base[MEMADDRBITS-1:ADDRBITS], cnt<=0, tag_valid<=0, go REQ.
  - inval=1 -> tag_valid<=0 (also when coincident with fill_req).
- REQ:
  - flush_mode=1, mem_rd=1, mem_addr={tag_out,cnt}.
  - On mem_valid: flush_in<=mem_data, flush_addr<=cnt, go WRITE.
  - mem_valid may arrive in the same cycle mem_rd is first seen; any wait length is allowed.
- WRITE:
  - flush_mode=1, flush_we=1 for exactly one cycle, mem_rd=0.
  - If cnt==MEMSIZE-1 -> go DONE; else cnt<=cnt+1 (wraps in ADDRBITS) and go REQ.
- DONE:
  - flush_mode=0, fill_done=1, tag_valid<=1 unless inval is high this cycle; go IDLE.

Handshake and boundary rules:
- fill_req while not in IDLE is ignored; no queueing.
- inval during REQ/WRITE does not abort the fill; it is recorded and blocks tag_valid from being set in DONE.
- mem_valid outside REQ is ignored.
- hit is forced 0 while fill_busy=1.

Timing, with fill_req accepted at cycle N and zero memory wait:
- mem_rd first high at N+1.
- First flush_we at N+2.
- Last flush_we at N+2*MEMSIZE.
- fill_done at N+2*MEMSIZE+1.
- Each wait cycle on mem_valid adds one cycle.

Decomposition:
- Shared package icache_pkg holds:
  - state encoding constants: ST_IDLE, ST_REQ, ST_WRITE, ST_DONE (2 bits);
  - default widths: ICACHE_DATABITS, ICACHE_ADDRBITS, ICACHE_MEMADDRBITS.
- No sub-module; the counter, FSM and tag register are one block.
- Instantiated next to the icache memory block in the icache top level.

Test Plan:
- Reset then idle: all outputs 0, hit=0 for any cpu_tag.
- fill_base=0x0000_0123, zero-wait memory returning data=word address:
  - mem_addr runs 0x120..0x13F;
  - flush_we pulses 32 times at flush_addr 0..31 with flush_in=0x120..0x13F;
  - fill_done at N+65;
  - then tag_valid=1, hit=1 for cpu_tag=0x9, hit=0 for cpu_tag=0xA.
- Memory with 3 wait cycles per word: fill_done at N+1+4*32+32=N+161; flush_in and flush_addr correct for every word; no extra flush_we.
- Second fill_req and spurious mem_valid during a fill: both ignored, word count stays 32; inval at word 10 -> fill completes but tag_valid=0 after DONE.
- reset_n pulsed low at word 17: all outputs 0 asynchronously; after release, a new fill_req starts cleanly at cnt=0.
